// File: rtl/mdu_iterative.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MDU_FASTPATH_EN lets divide-by-zero, signed overflow and zero multiplies skip ITER.
module mdu_iterative #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      FUN3,
  input  logic            OP_32,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  localparam int HW = XLEN / 2;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        fun3_q, fun3_d;
  logic              op32_q, op32_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d, dz_q, dz_d, busy_q, busy_d, done_q, done_d;
`ifdef MDU_FASTPATH_EN
  logic              fast_q, fast_d, ovf, dz_now, mz;
  logic [XLEN-1:0]   fast_res_q, fast_res_d;
`endif

  // Operand conditioning: width truncation, sign extension and magnitudes.
  logic            is_div, is_rem, sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] x1, x2, mag1, mag2;
  always_comb begin
    is_div = fun3_q[2];
    is_rem = fun3_q[2] & fun3_q[1];
    if (is_div) begin
      sgn1 = ~fun3_q[0];
      sgn2 = ~fun3_q[0];
    end else begin
      sgn1 = (fun3_q[1:0] == 2'd1) | (fun3_q[1:0] == 2'd2) | (op32_q & (fun3_q[1:0] == 2'd0));
      sgn2 = (fun3_q[1:0] == 2'd1) | (op32_q & (fun3_q[1:0] == 2'd0));
    end
    x1   = op32_q ? {{HW{sgn1 & rs1_q[HW-1]}}, rs1_q[HW-1:0]} : rs1_q;
    x2   = op32_q ? {{HW{sgn2 & rs2_q[HW-1]}}, rs2_q[HW-1:0]} : rs2_q;
    neg1 = sgn1 & x1[XLEN-1];
    neg2 = sgn2 & x2[XLEN-1];
    mag1 = neg1 ? -x1 : x1;
    mag2 = neg2 ? -x2 : x2;
  end

  // One iteration step: acc holds {hi, lo} = {partial product, multiplier}
  // for multiply and {remainder, dividend/quotient} for divide.
  logic [XLEN:0]   msum, dtmp;
  logic            dge;
  logic [XLEN-1:0] drem;
  always_comb begin
    msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    dtmp = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    dge  = dtmp >= {1'b0, b_q};
    drem = dge ? (dtmp[XLEN-1:0] - b_q) : dtmp[XLEN-1:0];
  end

  // Final sign correction and half selection.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   qv, rv, pre, fix_res;
  always_comb begin
    // A W-form multiply ran only 32 steps, so the product sits 32 bits up.
    prod   = op32_q ? (acc_q >> HW) : acc_q;
    prod_s = neg_q ? -prod : prod;
    qv     = acc_q[XLEN-1:0];
    rv     = acc_q[2*XLEN-1:XLEN];
    if (is_div) begin
      if (dz_q)        pre = is_rem ? rs1_q : {XLEN{1'b1}};
      else if (is_rem) pre = neg_q ? -rv : rv;
      else             pre = neg_q ? -qv : qv;
    end else if (op32_q && fun3_q[1:0] != 2'd0) begin
      pre = '0;
    end else if (fun3_q[1:0] == 2'd0) begin
      pre = prod_s[XLEN-1:0];
    end else begin
      pre = prod_s[2*XLEN-1:XLEN];
    end
`ifdef MDU_FASTPATH_EN
    if (fast_q) pre = fast_res_q;
`endif
    fix_res = op32_q ? {{HW{pre[HW-1]}}, pre[HW-1:0]} : pre;
  end

  always_comb begin
    state_d  = state_q;
    fun3_d   = fun3_q;
    op32_d   = op32_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
`ifdef MDU_FASTPATH_EN
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    dz_now     = is_div & (mag2 == '0);
    ovf        = is_div & sgn1 & (x2 == {XLEN{1'b1}}) &
                 (op32_q ? (x1 == {{(HW+1){1'b1}}, {(HW-1){1'b0}}})
                         : (x1 == {1'b1, {(XLEN-1){1'b0}}}));
    mz         = ~is_div & ((mag1 == '0) | (mag2 == '0));
`endif
    case (state_q)
      S_IDLE: if (START) begin
        fun3_d  = FUN3;
        op32_d  = OP_32;
        rs1_d   = RS1;
        rs2_d   = RS2;
        busy_d  = 1'b1;
        state_d = S_PREP;
      end
      S_PREP: begin
        // Divide dividend is left-aligned so the MSB-first loop works for both widths.
        acc_d   = is_div ? {{XLEN{1'b0}}, (op32_q ? (mag1 << HW) : mag1)}
                         : {{XLEN{1'b0}}, mag2};
        b_d     = is_div ? mag2 : mag1;
        neg_d   = is_rem ? neg1 : (neg1 ^ neg2);
        dz_d    = is_div & (mag2 == '0);
        cnt_d   = op32_q ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
        state_d = S_ITER;
`ifdef MDU_FASTPATH_EN
        fast_d     = dz_now | ovf | mz;
        fast_res_d = dz_now ? (is_rem ? rs1_q : {XLEN{1'b1}})
                            : ((ovf & ~is_rem) ? x1 : '0);
        if (dz_now | ovf | mz) state_d = S_FIX;
`endif
      end
      S_ITER: begin
        acc_d = is_div ? {drem, acc_q[XLEN-2:0], dge} : {msum, acc_q[XLEN-1:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (FLUSH) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      fun3_q   <= '0;
      op32_q   <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MDU_FASTPATH_EN
      fast_q     <= 1'b0;
      fast_res_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fun3_q   <= fun3_d;
      op32_q   <= op32_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef MDU_FASTPATH_EN
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
`endif
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
endmodule
